perm_scheduler: RTL and testbench
=================================

PERM_SCHEDULER -- requirements
Module: perm_scheduler

Interface
REQ-001 Parameter ROUND_W, default 4: width of round index output.
REQ-002 Parameter ROUND_LAST, default 11: index of final permutation round.
REQ-003 clock_i  input  1  single clock; all state changes on rising edge.
REQ-004 resetb_i  input  1  reset, synchronous, active-low; one clock, reset synchronous active-low, is fixed.
REQ-005 start_i  input  1  request one permutation; sampled only in IDLE.
REQ-006 mode_i  input  2  rounds select: 00 p12, 01 p8, 10 p6, 11 reserved (treated as p12).
REQ-007 round_o  output  ROUND_W  round index driving round-constant addition.
REQ-008 en_state_o  output  1  enable for 320-bit state register.
REQ-009 sel_input_o  output  1  1 = state mux takes external state, 0 = register feedback.
REQ-010 busy_o  output  1  high while rounds execute.
REQ-011 done_o  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; all outputs decoded from registered state and counter only (Moore, no input-to-output path).
REQ-013 IDLE: en_state_o=0, sel_input_o=0, busy_o=0, done_o=0, round_o=0.
REQ-014 IDLE with start_i=1 at an edge SHALL capture mode_i, load counter with first index (p12: 0, p8: 4, p6: 6), enter RUN.
REQ-015 RUN: en_state_o=1, busy_o=1, round_o=counter; sel_input_o=1 only in the first RUN cycle, 0 after.
REQ-016 RUN: counter SHALL increment by 1 per cycle; when counter=ROUND_LAST, next state SHALL be DONE.
REQ-017 RUN SHALL last exactly 12, 8 or 6 cycles for p12, p8, p6.
REQ-018 DONE: done_o=1, en_state_o=0, busy_o=0, sel_input_o=0, round_o holds ROUND_LAST; next state IDLE unconditionally.
REQ-019 Latency: start_i sampled at edge k -> done_o high during cycle k+13 (p12), k+9 (p8), k+7 (p6).
REQ-020 start_i in RUN or DONE SHALL be ignored; no queuing; mode_i changes after capture SHALL have no effect.
REQ-021 Back-to-back: start_i held high SHALL launch next permutation from IDLE, one idle cycle between done_o and next RUN.
REQ-022 Counter SHALL never exceed ROUND_LAST; no wrap-around reachable.

Reset
REQ-023 resetb_i=0 at an edge SHALL force IDLE, counter=0, captured mode=p12, regardless of state or start_i.
REQ-024 Reset mid-RUN SHALL abort: en_state_o=0 from next cycle, no done_o pulse issued.
REQ-025 All outputs SHALL equal IDLE values in the cycle following a reset edge.

Structure
REQ-026 Shared package (ascon_pack) SHALL hold: mode enum (P12, P8, P6), FSM state enum, first-round constants per mode, ROUND_LAST default.
REQ-027 One sub-module round_counter (load, increment enable, terminal flag) SHALL be instantiated; FSM in perm_scheduler.
REQ-028 Block drives enable/select of existing 320-bit state register; contains no datapath.

Verification
REQ-029 Reset then start_i=1 one cycle, mode_i=00 -> sel_input_o=1 one cycle, round_o 0..11, en_state_o=1 for 12 cycles, done_o pulse at k+13.
REQ-030 mode_i=10 (p6) -> round_o 6..11, 6 RUN cycles, done_o at k+7; mode_i=01 -> round_o 4..11, done_o at k+9.
REQ-031 mode_i=11 -> identical to p12 sequence.
REQ-032 start_i pulsed during RUN at round 5, mode_i toggled -> sequence unchanged, single done_o.
REQ-033 resetb_i=0 at round_o=7 -> next cycle IDLE outputs, no done_o; following start works normally.
REQ-034 start_i held high 30 cycles, p6 -> done_o at k+7, next sel_input_o=1 at k+9, repeating.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and round constants for the Ascon permutation scheduler.
package ascon_pack;

  localparam int ROUND_LAST_DEF = 11;
  localparam int FIRST_P12      = 0;
  localparam int FIRST_P8       = 4;
  localparam int FIRST_P6       = 6;

  typedef enum logic [1:0] {
    MODE_P12 = 2'b00,
    MODE_P8  = 2'b01,
    MODE_P6  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The reserved encoding 2'b11 falls back to the full 12-round permutation.
  function automatic mode_e mode_decode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_P8;
      2'b10:   return MODE_P6;
      default: return MODE_P12;
    endcase
  endfunction

  // Rounds always end on the last index, so the start index is an offset back from it.
  function automatic int first_round(input mode_e m, input int last);
    case (m)
      MODE_P8: return last - (ROUND_LAST_DEF - FIRST_P8);
      MODE_P6: return last - (ROUND_LAST_DEF - FIRST_P6);
      default: return last - (ROUND_LAST_DEF - FIRST_P12);
    endcase
  endfunction

endpackage

// File: rtl/round_counter.sv
// Loadable round index counter that saturates at the final round index.
module round_counter #(
  parameter int W    = 4,
  parameter int LAST = 11
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_last
);

  assign at_last = (count == W'(LAST));

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && !at_last) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/perm_scheduler.sv
// Round sequencer for the Ascon permutation: drives the state register enable/select and round index.
module perm_scheduler
  import ascon_pack::*;
#(
  parameter int ROUND_W    = 4,
  parameter int ROUND_LAST = ROUND_LAST_DEF
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               en_state_o,
  output logic               sel_input_o,
  output logic               busy_o,
  output logic               done_o
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_in;
  logic [ROUND_W-1:0]   count, load_value;
  logic                 load, inc, at_last;

  assign mode_in    = mode_decode(mode_i);
  assign load_value = ROUND_W'(first_round(mode_in, ROUND_LAST));

  round_counter #(
    .W    (ROUND_W),
    .LAST (ROUND_LAST)
  ) u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load       (load),
    .load_value (load_value),
    .inc        (inc),
    .count      (count),
    .at_last    (at_last)
  );

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_P12;
    end else begin
      state_q <= state_d;
      if (load) mode_q <= mode_in;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        inc = 1'b1;
        if (at_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode: the first RUN cycle is recognised by the counter still sitting on the start index.
  always_comb begin
    round_o     = '0;
    en_state_o  = 1'b0;
    sel_input_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      ST_RUN: begin
        round_o     = count;
        en_state_o  = 1'b1;
        busy_o      = 1'b1;
        sel_input_o = (count == ROUND_W'(first_round(mode_q, ROUND_LAST)));
      end
      ST_DONE: begin
        round_o = count;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_perm_scheduler.sv
// Directed bench for perm_scheduler: per-cycle output vectors {round, en, sel, busy, done}.
module tb_perm_scheduler;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic [3:0] round_o;
  logic       en_state_o, sel_input_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] IDLE_V = 8'b0000_0000;
  localparam logic [7:0] DONE_V = {4'd11, 1'b0, 1'b0, 1'b0, 1'b1};

  perm_scheduler #(.ROUND_W(4), .ROUND_LAST(11)) dut (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .round_o     (round_o),
    .en_state_o  (en_state_o),
    .sel_input_o (sel_input_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {round_o, en_state_o, sel_input_o, busy_o, done_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={rnd=%0d en=%b sel=%b busy=%b done=%b} expected={rnd=%0d en=%b sel=%b busy=%b done=%b}",
             tag, obs[7:4], obs[3], obs[2], obs[1], obs[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] run_v(input int r, input int first);
    return {4'(r), 1'b1, (r == first), 1'b1, 1'b0};
  endfunction

  // Launch one permutation; optionally disturb start/mode at pulse_at or reset at abort_at.
  task automatic run_perm(input logic [1:0] m, input int first, input int pulse_at, input int abort_at);
    mode_i  = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int r = first; r <= 11; r++) begin
      chk($sformatf("run m%0d r%0d", m, r), run_v(r, first));
      if (r == abort_at) begin
        resetb_i = 1'b0;
        tick();
        chk($sformatf("abort m%0d idle", m), IDLE_V);
        resetb_i = 1'b1;
        tick();
        chk($sformatf("abort m%0d nodone", m), IDLE_V);
        return;
      end
      if (r == pulse_at) begin
        start_i = 1'b1;
        mode_i  = ~m;
      end else begin
        start_i = 1'b0;
        mode_i  = m;
      end
      tick();
    end
    start_i = 1'b0;
    chk($sformatf("done m%0d", m), DONE_V);
    tick();
    chk($sformatf("after m%0d", m), IDLE_V);
  endtask

  initial begin
    resetb_i = 1'b0;
    start_i  = 1'b1;
    mode_i   = 2'b10;
    tick();
    chk("reset idle", IDLE_V);
    tick();
    chk("reset hold", IDLE_V);
    resetb_i = 1'b1;
    start_i  = 1'b0;
    tick();
    chk("idle no start", IDLE_V);

    run_perm(2'b00, 0, -1, -1);
    run_perm(2'b10, 6, -1, -1);
    run_perm(2'b01, 4, -1, -1);
    run_perm(2'b11, 0, -1, -1);
    run_perm(2'b00, 0, 5, -1);
    run_perm(2'b01, 4, -1, 7);
    run_perm(2'b00, 0, -1, 7);
    run_perm(2'b10, 6, -1, -1);

    // start held high with p6: RUN 6..11, DONE, IDLE, repeat every 8 cycles
    start_i = 1'b1;
    mode_i  = 2'b10;
    for (int i = 0; i < 30; i++) begin
      int ph;
      tick();
      ph = i % 8;
      if (ph < 6)       chk($sformatf("hold c%0d", i), run_v(6 + ph, 6));
      else if (ph == 6) chk($sformatf("hold c%0d", i), DONE_V);
      else              chk($sformatf("hold c%0d", i), IDLE_V);
    end
    start_i = 1'b0;
    tick();
    chk("hold tail done", DONE_V);
    tick();
    chk("hold tail idle", IDLE_V);
    tick();
    chk("hold tail stay", IDLE_V);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
